// File: rtl/clken_pkg.sv
// Shared constants and helpers for the clock-enable bank.
package clken_pkg;

   localparam int ACC_W_DEF = 32;  // default accumulator / increment width
   localparam int MAX_CH    = 16;  // largest supported channel count

   typedef longint unsigned u64_t;

   // Increment giving an average enable rate of f_out_hz from f_ref_hz,
   // rounded to nearest. Intended for benches and top-level constants.
   function automatic u64_t inc_for(real f_out_hz, real f_ref_hz,
                                    int acc_w = ACC_W_DEF);
      real scale;
      scale = 1.0;
      for (int i = 0; i < acc_w; i++) scale = scale * 2.0;
      return u64_t'($floor(f_out_hz * scale / f_ref_hz + 0.5));
   endfunction

endpackage

// File: rtl/clken_bank_if.sv
// Control / status bundle of the clock-enable bank.
// Handshake: wr is a one-cycle strobe qualified by wr_ch/wr_inc; there is no
// ready/back-pressure, a write is always accepted and busy[ch] reports that
// the new increment has not yet taken effect. align is a one-cycle strobe.
interface clken_bank_if import clken_pkg::*; #(
   parameter int NUM_CH = 7,
   parameter int ACC_W  = ACC_W_DEF
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              wr;
   logic [CH_W-1:0]   wr_ch;
   logic [ACC_W-1:0]  wr_inc;
   logic              align;
   logic [NUM_CH-1:0] ce;
   logic              ready;
   logic [NUM_CH-1:0] busy;

   modport master (output wr, wr_ch, wr_inc, align, input ce, ready, busy);
   modport slave  (input wr, wr_ch, wr_inc, align, output ce, ready, busy);

endinterface

// File: rtl/clken_acc_ch.sv
// One fractional clock-enable channel: phase accumulator plus a staged
// increment that only takes effect at a glitch-free point.
module clken_acc_ch import clken_pkg::*; #(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             run,     // lock synchronised and settled
   input  logic             align,
   input  logic             wr,      // write addressed to this channel
   input  logic [ACC_W-1:0] wr_inc,
   output logic             ce,
   output logic             busy
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_act;
   logic [ACC_W-1:0] pending;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic             apply;

   // Wrap detection and the points where a staged increment may be applied:
   // on a wrap, while the channel is off, while halted, or on align.
   always_comb begin
      sum   = {1'b0, acc} + {1'b0, inc_act};
      carry = sum[ACC_W];
      apply = busy && (carry || (inc_act == '0) || !run || align);
   end

   // Phase accumulator; the wrap edge itself still uses the old increment.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ce  <= 1'b0;
      end else if (!run || align) begin
         acc <= '0;
         ce  <= 1'b0;
      end else begin
         acc <= sum[ACC_W-1:0];
         ce  <= carry;
      end
   end

   // Increment staging; a write on the apply edge wins and keeps busy set.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         inc_act <= '0;
         pending <= '0;
         busy    <= 1'b0;
      end else begin
         if (apply) begin
            inc_act <= pending;
            busy    <= 1'b0;
         end
         if (wr) begin
            pending <= wr_inc;
            busy    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clken_bank.sv
// Multi-channel fractional clock-enable generator with lock gating.
module clken_bank import clken_pkg::*; #(
   parameter int NUM_CH = 7,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int SETTLE = 1024
) (
   input  logic        refclk,
   input  logic        rst_n,
   input  logic        pll_locked,
   clken_bank_if.slave bus
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(SETTLE + 1);

   logic             lk_meta;
   logic             lk_s;
   logic [CNT_W-1:0] settle_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             ready_q;
   logic             run;
   logic [NUM_CH-1:0] ce_v;
   logic [NUM_CH-1:0] busy_v;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lk_meta <= 1'b0;
         lk_s    <= 1'b0;
      end else begin
         lk_meta <= pll_locked;
         lk_s    <= lk_meta;
      end
   end

   // Settle counter: cleared while unlocked, saturates at SETTLE.
   always_comb begin
      cnt_next = '0;
      if (lk_s) begin
         if (settle_cnt == CNT_W'(SETTLE)) cnt_next = settle_cnt;
         else                              cnt_next = settle_cnt + 1'b1;
      end
   end

   // Settle count register and registered ready.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         ready_q    <= 1'b0;
      end else begin
         settle_cnt <= cnt_next;
         ready_q    <= (cnt_next == CNT_W'(SETTLE));
      end
   end

   // Halting on lk_s as well as ready lets the first unlocked edge clear
   // the channels together with ready.
   assign run       = ready_q & lk_s;
   assign bus.ready = ready_q;
   assign bus.ce    = ce_v;
   assign bus.busy  = busy_v;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic wr_hit;
      // Out-of-range channel numbers match no instance and are dropped.
      assign wr_hit = bus.wr && (bus.wr_ch == CH_W'(c));

      clken_acc_ch #(.ACC_W(ACC_W)) u_ch (
         .refclk (refclk),
         .rst_n  (rst_n),
         .run    (run),
         .align  (bus.align),
         .wr     (wr_hit),
         .wr_inc (bus.wr_inc),
         .ce     (ce_v[c]),
         .busy   (busy_v[c])
      );
   end

endmodule

// File: tb/tb_clken_bank.sv
// Self-checking bench for clken_bank (NUM_CH=7, ACC_W=8, SETTLE=4).
module tb_clken_bank;
   import clken_pkg::*;

   localparam int NUM_CH = 7;
   localparam int ACC_W  = 8;
   localparam int SETTLE = 4;
   localparam int CH_W   = 3;
   localparam int MODV   = 1 << ACC_W;
   localparam int OUT_W  = 2 * NUM_CH + 1;

   // ---------------- clock / reset ----------------
   logic refclk = 1'b0;
   logic rst_n;
   logic pll_locked;

   always #5 refclk = ~refclk;

   clken_bank_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

   clken_bank #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE(SETTLE)) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .bus        (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   bit m_s1, m_lk, m_ready;
   int m_cnt;
   int m_acc  [NUM_CH];
   int m_act  [NUM_CH];
   int m_pend [NUM_CH];
   bit m_busy [NUM_CH];
   bit m_ce   [NUM_CH];

   logic [OUT_W-1:0] exp_q[$];

   function automatic void model_reset();
      m_s1 = 0; m_lk = 0; m_ready = 0; m_cnt = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_acc[c] = 0; m_act[c] = 0; m_pend[c] = 0; m_busy[c] = 0; m_ce[c] = 0;
      end
   endfunction

   function automatic void model_edge(bit w, int ch, int inc, bit al);
      bit run;
      int n_cnt;
      int sum;
      bit carry, apply;
      run   = m_ready && m_lk;
      n_cnt = !m_lk ? 0 : ((m_cnt < SETTLE) ? m_cnt + 1 : SETTLE);
      for (int c = 0; c < NUM_CH; c++) begin
         sum   = m_acc[c] + m_act[c];
         carry = (sum >= MODV);
         apply = m_busy[c] && (carry || m_act[c] == 0 || !run || al);
         if (!run || al) begin
            m_acc[c] = 0; m_ce[c] = 0;
         end else begin
            m_acc[c] = sum % MODV; m_ce[c] = carry;
         end
         if (apply) begin
            m_act[c] = m_pend[c]; m_busy[c] = 0;
         end
         if (w && ch == c) begin
            m_pend[c] = inc; m_busy[c] = 1;
         end
      end
      m_ready = (n_cnt == SETTLE);
      m_cnt   = n_cnt;
      m_lk    = m_s1;
      m_s1    = pll_locked;
   endfunction

   function automatic logic [OUT_W-1:0] model_pack();
      logic [NUM_CH-1:0] ce_b, busy_b;
      for (int c = 0; c < NUM_CH; c++) begin
         ce_b[c] = m_ce[c]; busy_b[c] = m_busy[c];
      end
      return {ce_b, m_ready, busy_b};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic sb_check();
      logic [OUT_W-1:0] exp, got;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
         exp = exp_q.pop_front();
         got = {bus.ce, bus.ready, bus.busy};
         if (got !== exp) begin
            errors++;
            $display("FAIL sb {ce,ready,busy}: got %h expected %h at %0t", got, exp, $time);
         end
      end
   endtask

   // ---------------- driver ----------------
   // Drive one edge worth of inputs, predict, then sample 1 ns after the edge.
   task automatic cyc(input bit w, input int ch, input int inc, input bit al);
      bus.wr     = w;
      bus.wr_ch  = CH_W'(ch);
      bus.wr_inc = ACC_W'(inc);
      bus.align  = al;
      model_edge(w, ch, inc, al);
      exp_q.push_back(model_pack());
      @(posedge refclk);
      #1;
      sb_check();
      bus.wr    = 1'b0;
      bus.align = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   // ---------------- directed rate table ----------------
   typedef struct {
      bit w; int ch; int inc; bit al; bit ce0; bit busy0;
   } vec_t;

   vec_t vecs[22];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int inc64, inc96, n;

      inc64 = int'(inc_for(25.0e6, 100.0e6, ACC_W));
      inc96 = int'(inc_for(37.5e6, 100.0e6, ACC_W));
      for (int k = 0; k < 22; k++) vecs[k] = '{0, 0, 0, 0, 0, 0};
      vecs[0].w = 1;  vecs[0].ch = 0; vecs[0].inc = inc64;
      vecs[9].w = 1;  vecs[9].ch = 0; vecs[9].inc = inc96;
      vecs[0].busy0 = 1;
      for (int k = 9; k <= 12; k++) vecs[k].busy0 = 1;
      vecs[5].ce0 = 1;  vecs[9].ce0 = 1;  vecs[13].ce0 = 1;
      vecs[16].ce0 = 1; vecs[19].ce0 = 1; vecs[21].ce0 = 1;

      // reset
      rst_n = 1'b0; pll_locked = 1'b0;
      bus.wr = 1'b0; bus.wr_ch = '0; bus.wr_inc = '0; bus.align = 1'b0;
      model_reset();
      #12;
      chk("reset_ce", bus.ce, 0);
      chk("reset_ready", bus.ready, 0);
      chk("reset_busy", bus.busy, 0);
      @(negedge refclk);
      rst_n = 1'b1;
      idle(1);

      // lock: ready after the 6th edge following pll_locked rising
      pll_locked = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc(0, 0, 0, 0);
         chk("lock_ready", bus.ready, (k == 6));
         chk("lock_ce", bus.ce, 0);
      end

      // rate table: inc 64 then retune to 96
      for (int k = 0; k < 22; k++) begin
         cyc(vecs[k].w, vecs[k].ch, vecs[k].inc, vecs[k].al);
         chk("rate_ce0", bus.ce[0], vecs[k].ce0);
         chk("rate_busy0", bus.busy[0], vecs[k].busy0);
      end

      // retune ch1 64 -> 128 mid-period
      cyc(1, 1, 64, 0);
      idle(6);
      cyc(1, 1, 128, 0);
      chk("retune_busy_wr", bus.busy[1], 1);
      for (int j = 1; j <= 6; j++) begin
         cyc(0, 0, 0, 0);
         chk("retune_ce1", bus.ce[1], (j == 2 || j == 4 || j == 6));
         chk("retune_busy1", bus.busy[1], (j < 2));
      end

      // out-of-range channel
      cyc(1, 7, 200, 0);
      chk("bad_ch_busy", bus.busy, 0);

      // off / on on ch1
      cyc(1, 1, 0, 0);
      chk("off_wr_ce1", bus.ce[1], 1);
      chk("off_wr_busy1", bus.busy[1], 1);
      cyc(0, 0, 0, 0);
      chk("off_mid_busy1", bus.busy[1], 1);
      cyc(0, 0, 0, 0);
      chk("off_last_ce1", bus.ce[1], 1);
      chk("off_apply_busy1", bus.busy[1], 0);
      for (int j = 0; j < 3; j++) begin
         cyc(0, 0, 0, 0);
         chk("off_quiet_ce1", bus.ce[1], 0);
      end
      cyc(1, 1, 32, 0);
      chk("on_wr_busy1", bus.busy[1], 1);
      cyc(0, 0, 0, 0);
      chk("on_apply_busy1", bus.busy[1], 0);

      // align ch0 and ch2 started apart
      cyc(1, 0, 64, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 2, 64, 0);
      idle(4);
      cyc(0, 0, 0, 1);
      chk("align_ce", bus.ce, 0);
      for (int j = 1; j <= 12; j++) begin
         cyc(0, 0, 0, 0);
         chk("align_ce0", bus.ce[0], (j % 4 == 0));
         chk("align_ce2", bus.ce[2], (j % 4 == 0));
      end

      // same-edge write + align on ch3: older pending (48) applied
      cyc(1, 3, 16, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 3, 48, 0);
      cyc(1, 3, 80, 1);
      chk("wr_align_busy3", bus.busy[3], 1);
      for (int j = 1; j <= 6; j++) begin
         cyc(0, 0, 0, 0);
         chk("wr_align_ce3", bus.ce[3], (j == 6));
         chk("wr_align_busy3", bus.busy[3], (j < 6));
      end

      // lock loss and relock
      pll_locked = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         cyc(0, 0, 0, 0);
         chk("loss_ready", bus.ready, (j < 3));
      end
      chk("loss_ce", bus.ce, 0);
      pll_locked = 1'b1;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc(0, 0, 0, 0);
         if (bus.ready) begin
            n = k;
            break;
         end
      end
      chk("relock_edges", n, SETTLE + 2);
      idle(20);

      // asynchronous reset mid-operation
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ce", bus.ce, 0);
      chk("async_rst_ready", bus.ready, 0);
      chk("async_rst_busy", bus.busy, 0);
      model_reset();
      @(negedge refclk);
      rst_n = 1'b1;
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
